xil_regbank_ctrl: RTL and testbench

- Controller between the Xillybus seekable 16-bit control/status streams and the user register space.
- Host write stream: maintains an auto-incrementing address pointer and commits words into a NUM_REGS-deep control register bank.
- Host read stream: sequences reads of the status bank word by word, with empty/eof flow control.
- Sits between the Xillybus core (bus_clk domain) and the acquisition engine's configuration inputs.

---
 rtl/xil_regbank_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_xil_regbank_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xil_regbank_ctrl.sv
// -----------------------------------------------------------------------------
// xil_regbank_ctrl
//
// Bridges the Xillybus seekable 16-bit control/status streams to the user
// register space.
//   * Host write stream: auto-incrementing write pointer that commits words
//     into a NUM_REGS-deep control register bank (ctrl_out).
//   * Host read stream: CLOSED/ACTIVE/DONE sequencer that returns the status
//     bank (status_in) word by word, with empty/eof flow control.
//
// Ports
//   bus_clk, trn_reset_n         clock (rising edge) / async active-low reset
//   wr_open, wr_addr_update,
//   wr_addr, wr_wren, wr_data    host write stream in
//   wr_full                      write full flag (tied 0)
//   rd_open, rd_addr_update,
//   rd_addr, rd_rden             host read stream in
//   rd_data, rd_empty, rd_eof    host read stream out (registered)
//   status_in                    flat status bank, reg i at [i*DATA_W +: DATA_W]
//   ctrl_out                     flat control bank, same packing
//   ctrl_wr_stb, ctrl_wr_idx     one-cycle pulse + index per committed write
//   wr_ovf                       sticky: write attempted past NUM_REGS-1
//
// Build option
//   XIL_REGBANK_SNAPSHOT_EN : when defined, the whole status bank is captured
//   into a shadow bank on rd_open rising and on every rd_addr_update, and
//   reads return the shadow for a coherent multi-word view. When undefined,
//   reads sample live status_in.
// -----------------------------------------------------------------------------
module xil_regbank_ctrl #(
    parameter int                ADDR_W         = 5,
    parameter int                DATA_W         = 16,
    parameter int                NUM_REGS       = 32,
    parameter logic [DATA_W-1:0] CTRL_RESET_VAL = '0
) (
    input  logic                         bus_clk,
    input  logic                         trn_reset_n,
    // host write stream
    input  logic                         wr_open,
    input  logic                         wr_addr_update,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic                         wr_wren,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         wr_full,
    // host read stream
    input  logic                         rd_open,
    input  logic                         rd_addr_update,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_rden,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_empty,
    output logic                         rd_eof,
    // user register space
    input  logic [NUM_REGS*DATA_W-1:0]   status_in,
    output logic [NUM_REGS*DATA_W-1:0]   ctrl_out,
    output logic                         ctrl_wr_stb,
    output logic [ADDR_W-1:0]            ctrl_wr_idx,
    output logic                         wr_ovf
);

    // Pointers carry one extra bit so they can sit at NUM_REGS (past the end).
    localparam int               PTR_W      = ADDR_W + 1;
    localparam logic [PTR_W-1:0] NUM_REGS_P = PTR_W'(NUM_REGS);
    localparam int               BANK_W     = NUM_REGS * DATA_W;

    typedef enum logic [1:0] {
        RD_CLOSED = 2'd0,
        RD_ACTIVE = 2'd1,
        RD_DONE   = 2'd2
    } rd_state_e;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic                wr_open_q;
    logic                wr_open_rise;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    wr_eff;
    logic                wr_ovf_q, wr_ovf_d;
    logic [BANK_W-1:0]   ctrl_q, ctrl_d;
    logic                ctrl_wr_stb_q, ctrl_wr_stb_d;
    logic [ADDR_W-1:0]   ctrl_wr_idx_q, ctrl_wr_idx_d;

    always_comb begin
        wr_open_rise = wr_open & ~wr_open_q;

        // Effective pointer for this cycle: reopen clears it, then a seek
        // overrides it, so a same-cycle wren lands at the seek address.
        wr_eff = wr_ptr_q;
        if (wr_open_rise) begin
            wr_eff = '0;
        end
        if (wr_addr_update) begin
            wr_eff = {1'b0, wr_addr};
        end

        wr_ptr_d      = wr_eff;
        wr_ovf_d      = wr_ovf_q & ~wr_open_rise;
        ctrl_d        = ctrl_q;
        ctrl_wr_stb_d = 1'b0;
        ctrl_wr_idx_d = ctrl_wr_idx_q;

        if (wr_wren && wr_open) begin
            if (wr_eff < NUM_REGS_P) begin
                ctrl_d[wr_eff[ADDR_W-1:0]*DATA_W +: DATA_W] = wr_data;
                ctrl_wr_stb_d = 1'b1;
                ctrl_wr_idx_d = wr_eff[ADDR_W-1:0];
                wr_ptr_d      = wr_eff + PTR_W'(1);
            end else begin
                // Past the end: drop the word, hold the pointer (no wrap).
                wr_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            wr_open_q     <= 1'b0;
            wr_ptr_q      <= '0;
            wr_ovf_q      <= 1'b0;
            ctrl_q        <= {NUM_REGS{CTRL_RESET_VAL}};
            ctrl_wr_stb_q <= 1'b0;
            ctrl_wr_idx_q <= '0;
        end else begin
            wr_open_q     <= wr_open;
            wr_ptr_q      <= wr_ptr_d;
            wr_ovf_q      <= wr_ovf_d;
            ctrl_q        <= ctrl_d;
            ctrl_wr_stb_q <= ctrl_wr_stb_d;
            ctrl_wr_idx_q <= ctrl_wr_idx_d;
        end
    end

    assign wr_full     = 1'b0;
    assign ctrl_out    = ctrl_q;
    assign ctrl_wr_stb = ctrl_wr_stb_q;
    assign ctrl_wr_idx = ctrl_wr_idx_q;
    assign wr_ovf      = wr_ovf_q;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic                rd_open_q;
    logic                rd_open_rise;
    rd_state_e           rd_state_q, rd_state_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_empty_q, rd_empty_d;
    logic                rd_eof_q, rd_eof_d;
    logic [BANK_W-1:0]   rd_src;

    assign rd_open_rise = rd_open & ~rd_open_q;

`ifdef XIL_REGBANK_SNAPSHOT_EN
    logic                snap_capture;
    logic [BANK_W-1:0]   shadow_q;

    assign snap_capture = rd_open_rise | rd_addr_update;

    // On a capture cycle the shadow is being loaded from status_in, so a
    // same-cycle read must see status_in to stay consistent with the snapshot.
    assign rd_src = snap_capture ? status_in : shadow_q;

    always_ff @(posedge bus_clk) begin
        if (snap_capture) begin
            shadow_q <= status_in;
        end
    end
`else
    assign rd_src = status_in;
`endif

    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;

        if (!rd_open) begin
            rd_state_d = RD_CLOSED;
        end else begin
            case (rd_state_q)
                RD_CLOSED: begin
                    if (rd_open_rise) begin
                        rd_ptr_d   = '0;
                        rd_state_d = RD_ACTIVE;
                    end
                end
                default: begin
                    // Seek first, so a same-cycle rden reads the new address.
                    if (rd_addr_update) begin
                        rd_ptr_d   = {1'b0, rd_addr};
                        rd_state_d = (rd_ptr_d < NUM_REGS_P) ? RD_ACTIVE : RD_DONE;
                    end
                    if (rd_rden && (rd_state_d == RD_ACTIVE)) begin
                        rd_data_d = rd_src[rd_ptr_d[ADDR_W-1:0]*DATA_W +: DATA_W];
                        rd_ptr_d  = rd_ptr_d + PTR_W'(1);
                        if (rd_ptr_d == NUM_REGS_P) begin
                            rd_state_d = RD_DONE;
                        end
                    end
                end
            endcase
        end

        // Flags follow the next state so they line up with the data edge.
        rd_empty_d = (rd_state_d != RD_ACTIVE);
        rd_eof_d   = (rd_state_d == RD_DONE);
    end

    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            rd_open_q  <= 1'b0;
            rd_state_q <= RD_CLOSED;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_empty_q <= 1'b1;
            rd_eof_q   <= 1'b0;
        end else begin
            rd_open_q  <= rd_open;
            rd_state_q <= rd_state_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_empty_q <= rd_empty_d;
            rd_eof_q   <= rd_eof_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_empty = rd_empty_q;
    assign rd_eof   = rd_eof_q;

endmodule

// File: tb/tb_xil_regbank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xil_regbank_ctrl
//
// Self-checking bench for xil_regbank_ctrl: directed scenarios with fixed
// expected values, followed by a randomized run compared cycle by cycle
// against an array/integer reference model of the register bank.
// -----------------------------------------------------------------------------
module tb_xil_regbank_ctrl;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int NR = 32;

    logic              clk;
    logic              trn_reset_n;
    logic              wr_open, wr_addr_update, wr_wren;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_full;
    logic              rd_open, rd_addr_update, rd_rden;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_empty, rd_eof;
    logic [NR*DW-1:0]  status_in;
    logic [NR*DW-1:0]  ctrl_out;
    logic              ctrl_wr_stb;
    logic [AW-1:0]     ctrl_wr_idx;
    logic              wr_ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    xil_regbank_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .CTRL_RESET_VAL('0)
    ) dut (
        .bus_clk       (clk),
        .trn_reset_n   (trn_reset_n),
        .wr_open       (wr_open),
        .wr_addr_update(wr_addr_update),
        .wr_addr       (wr_addr),
        .wr_wren       (wr_wren),
        .wr_data       (wr_data),
        .wr_full       (wr_full),
        .rd_open       (rd_open),
        .rd_addr_update(rd_addr_update),
        .rd_addr       (rd_addr),
        .rd_rden       (rd_rden),
        .rd_data       (rd_data),
        .rd_empty      (rd_empty),
        .rd_eof        (rd_eof),
        .status_in     (status_in),
        .ctrl_out      (ctrl_out),
        .ctrl_wr_stb   (ctrl_wr_stb),
        .ctrl_wr_idx   (ctrl_wr_idx),
        .wr_ovf        (wr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: plain arrays and integers
    // ------------------------------------------------------------------
    logic [DW-1:0] m_ctrl   [NR];
    logic [DW-1:0] m_shadow [NR];
    int            m_wptr;
    bit            m_wovf, m_stb;
    int            m_idx;
    bit            m_wopen_prev, m_ropen_prev, m_opened;
    int            m_pos;
    logic [DW-1:0] m_rdata;

    function automatic logic [NR*DW-1:0] model_ctrl_flat();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_ctrl[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_ctrl[i] = '0;
        m_wptr = 0; m_wovf = 0; m_stb = 0; m_idx = 0;
        m_wopen_prev = 0; m_ropen_prev = 0; m_opened = 0;
        m_pos = 0; m_rdata = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [DW-1:0] live [NR];
        bit w_rise, r_rise;
        for (int i = 0; i < NR; i++) live[i] = status_in[i*DW +: DW];

        w_rise = wr_open && !m_wopen_prev;
        if (w_rise) begin m_wptr = 0; m_wovf = 0; end
        if (wr_addr_update) m_wptr = int'(wr_addr);
        m_stb = 0;
        if (wr_wren && wr_open) begin
            if (m_wptr < NR) begin
                m_ctrl[m_wptr] = wr_data;
                m_stb = 1; m_idx = m_wptr; m_wptr++;
            end else begin
                m_wovf = 1;
            end
        end
        m_wopen_prev = wr_open;

        r_rise = rd_open && !m_ropen_prev;
`ifdef XIL_REGBANK_SNAPSHOT_EN
        if (r_rise || rd_addr_update)
            for (int i = 0; i < NR; i++) m_shadow[i] = live[i];
`else
        for (int i = 0; i < NR; i++) m_shadow[i] = live[i];
`endif
        if (!rd_open) begin
            m_opened = 0;
        end else if (r_rise) begin
            m_opened = 1; m_pos = 0;
        end else if (m_opened) begin
            if (rd_addr_update) m_pos = int'(rd_addr);
            if (rd_rden && m_pos < NR) begin
                m_rdata = m_shadow[m_pos];
                m_pos++;
            end
        end
        m_ropen_prev = rd_open;
    endtask

    // One clock: model consumes the applied inputs, outputs settle #1 later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_open = 0; wr_addr_update = 0; wr_addr = '0; wr_wren = 0; wr_data = '0;
        rd_open = 0; rd_addr_update = 0; rd_addr = '0; rd_rden = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        wr_open = 1; tick();
        wr_addr_update = 1; wr_addr = 5'd7; wr_wren = 1; wr_data = 16'hDEAD; tick();
        tests_run++;
        if (ctrl_out[7*DW +: DW] !== 16'hDEAD) begin
            tests_failed++;
            $display("FAIL pre_reset_write reg7 got %h want DEAD", ctrl_out[7*DW +: DW]);
        end
        // Reset lands mid-cycle while a write is pending.
        wr_addr_update = 0; wr_data = 16'hBEEF;
        #2 trn_reset_n = 0;
        model_reset();
        #1;
        tests_run++;
        if (ctrl_out !== '0 || wr_ovf !== 1'b0 || ctrl_wr_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset ctrl_or=%b ovf=%b stb=%b want 0 0 0", |ctrl_out, wr_ovf, ctrl_wr_stb);
        end
        tests_run++;
        if (rd_empty !== 1'b1 || rd_eof !== 1'b0 || rd_data !== '0 || ctrl_wr_idx !== '0) begin
            tests_failed++;
            $display("FAIL async_reset_rd empty=%b eof=%b data=%h idx=%0d want 1 0 0000 0",
                     rd_empty, rd_eof, rd_data, ctrl_wr_idx);
        end
        clear_inputs();
        @(posedge clk); #3 trn_reset_n = 1;
        tick();
        tests_run++;
        if (ctrl_out !== '0 || rd_empty !== 1'b1 || rd_eof !== 1'b0 || wr_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset ctrl_or=%b empty=%b eof=%b ovf=%b want 0 1 0 0",
                     |ctrl_out, rd_empty, rd_eof, wr_ovf);
        end
    endtask

    task automatic test_burst_write();
        wr_open = 1; tick();
        wr_addr_update = 1; wr_addr = 5'd3; wr_wren = 1; wr_data = 16'hA5A5; tick();
        tests_run++;
        if (ctrl_wr_stb !== 1'b1 || ctrl_wr_idx !== 5'd3 || ctrl_out[3*DW +: DW] !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL burst_first stb=%b idx=%0d reg3=%h want 1 3 A5A5",
                     ctrl_wr_stb, ctrl_wr_idx, ctrl_out[3*DW +: DW]);
        end
        wr_addr_update = 0; wr_data = 16'h1234; tick();
        tests_run++;
        if (ctrl_wr_stb !== 1'b1 || ctrl_wr_idx !== 5'd4 || ctrl_out[4*DW +: DW] !== 16'h1234
            || ctrl_out[3*DW +: DW] !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL burst_second stb=%b idx=%0d reg4=%h reg3=%h want 1 4 1234 A5A5",
                     ctrl_wr_stb, ctrl_wr_idx, ctrl_out[4*DW +: DW], ctrl_out[3*DW +: DW]);
        end
        wr_wren = 0; tick();
        tests_run++;
        if (ctrl_wr_stb !== 1'b0 || wr_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_idle stb=%b full=%b want 0 0", ctrl_wr_stb, wr_full);
        end
    endtask

    task automatic test_write_overflow();
        wr_addr_update = 1; wr_addr = 5'd31; wr_wren = 1; wr_data = 16'h1111; tick();
        wr_addr_update = 0; wr_data = 16'h2222; tick();
        tests_run++;
        if (ctrl_wr_stb !== 1'b0 || wr_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_second stb=%b ovf=%b want 0 1", ctrl_wr_stb, wr_ovf);
        end
        wr_data = 16'h3333; tick();
        wr_wren = 0; tick();
        tests_run++;
        if (ctrl_out[31*DW +: DW] !== 16'h1111 || wr_ovf !== 1'b1 || ctrl_out[0 +: DW] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL ovf_hold reg31=%h ovf=%b reg0=%h want 1111 1 0000",
                     ctrl_out[31*DW +: DW], wr_ovf, ctrl_out[0 +: DW]);
        end
        // Write while closed is ignored, reopening clears the flag and pointer.
        wr_open = 0; wr_wren = 1; wr_data = 16'h7777; tick();
        wr_wren = 0; wr_open = 1; tick();
        tests_run++;
        if (wr_ovf !== 1'b0 || ctrl_wr_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_reopen ovf=%b stb=%b want 0 0", wr_ovf, ctrl_wr_stb);
        end
        wr_wren = 1; wr_data = 16'h0F0F; tick();
        wr_wren = 0;
        tests_run++;
        if (ctrl_wr_idx !== 5'd0 || ctrl_out[0 +: DW] !== 16'h0F0F) begin
            tests_failed++;
            $display("FAIL reopen_ptr idx=%0d reg0=%h want 0 0F0F", ctrl_wr_idx, ctrl_out[0 +: DW]);
        end
    endtask

    task automatic test_full_read();
        for (int i = 0; i < NR; i++) status_in[i*DW +: DW] = 16'(16'h100 + i);
        rd_open = 1; tick();
        tests_run++;
        if (rd_empty !== 1'b0 || rd_eof !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_open empty=%b eof=%b want 0 0", rd_empty, rd_eof);
        end
        for (int i = 0; i < NR; i++) begin
            rd_rden = 1; tick();
            tests_run++;
            if (rd_data !== 16'(16'h100 + i) || rd_empty !== (i == NR-1) || rd_eof !== (i == NR-1)) begin
                tests_failed++;
                $display("FAIL full_read[%0d] data=%h empty=%b eof=%b want %h %b %b",
                         i, rd_data, rd_empty, rd_eof, 16'(16'h100 + i), i == NR-1, i == NR-1);
            end
        end
        rd_rden = 0;
    endtask

    task automatic test_read_seek();
        rd_rden = 1; tick();
        tests_run++;
        if (rd_data !== 16'h011F || rd_eof !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_rden_ignored data=%h eof=%b want 011F 1", rd_data, rd_eof);
        end
        rd_rden = 0; rd_addr_update = 1; rd_addr = 5'd30; tick();
        rd_addr_update = 0;
        tests_run++;
        if (rd_empty !== 1'b0 || rd_eof !== 1'b0) begin
            tests_failed++;
            $display("FAIL seek30 empty=%b eof=%b want 0 0", rd_empty, rd_eof);
        end
        rd_rden = 1; tick();
        tests_run++;
        if (rd_data !== 16'h011E || rd_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL seek_read30 data=%h empty=%b want 011E 0", rd_data, rd_empty);
        end
        tick();
        tests_run++;
        if (rd_data !== 16'h011F || rd_empty !== 1'b1 || rd_eof !== 1'b1) begin
            tests_failed++;
            $display("FAIL seek_read31 data=%h empty=%b eof=%b want 011F 1 1", rd_data, rd_empty, rd_eof);
        end
        rd_rden = 0; rd_addr_update = 1; rd_addr = 5'd0; tick();
        tests_run++;
        if (rd_empty !== 1'b0 || rd_eof !== 1'b0) begin
            tests_failed++;
            $display("FAIL seek0 empty=%b eof=%b want 0 0", rd_empty, rd_eof);
        end
        // Seek and read in the same cycle returns the new address.
        rd_addr = 5'd10; rd_rden = 1; tick();
        rd_addr_update = 0; rd_rden = 0;
        tests_run++;
        if (rd_data !== 16'h010A) begin
            tests_failed++;
            $display("FAIL seek_same_cycle data=%h want 010A", rd_data);
        end
        rd_open = 0; tick();
        tests_run++;
        if (rd_empty !== 1'b1 || rd_eof !== 1'b0 || rd_data !== 16'h010A) begin
            tests_failed++;
            $display("FAIL read_close empty=%b eof=%b data=%h want 1 0 010A", rd_empty, rd_eof, rd_data);
        end
    endtask

    task automatic test_snapshot();
        logic [DW-1:0] want;
`ifdef XIL_REGBANK_SNAPSHOT_EN
        want = 16'h0105;
`else
        want = 16'hBEEF;
`endif
        status_in[5*DW +: DW] = 16'h0105;
        rd_open = 1; tick();
        status_in[5*DW +: DW] = 16'hBEEF;
        rd_rden = 1;
        for (int i = 0; i < 6; i++) tick();
        rd_rden = 0;
        tests_run++;
        if (rd_data !== want) begin
            tests_failed++;
            $display("FAIL snapshot_reg5 data=%h want %h", rd_data, want);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(49) == 0) wr_open = ~wr_open;
            if ($urandom_range(39) == 0) rd_open = ~rd_open;
            wr_addr_update = ($urandom_range(11) == 0);
            wr_addr        = AW'($urandom);
            wr_wren        = $urandom_range(1);
            wr_data        = DW'($urandom);
            rd_addr_update = ($urandom_range(11) == 0);
            rd_addr        = AW'($urandom);
            rd_rden        = $urandom_range(1);
            status_in[$urandom_range(NR-1)*DW +: DW] = DW'($urandom);
            tick();
            if (cyc == 1500) begin
                #2 trn_reset_n = 0;
                model_reset();
                #2 trn_reset_n = 1;
            end
            tests_run++;
            if (ctrl_out !== model_ctrl_flat() || wr_ovf !== m_wovf || ctrl_wr_stb !== m_stb
                || ctrl_wr_idx !== AW'(m_idx)) begin
                tests_failed++;
                $display("FAIL rand_wr cyc=%0d ovf=%b stb=%b idx=%0d want %b %b %0d ctrl_match=%b",
                         cyc, wr_ovf, ctrl_wr_stb, ctrl_wr_idx, m_wovf, m_stb, m_idx,
                         ctrl_out === model_ctrl_flat());
            end
            tests_run++;
            if (rd_data !== m_rdata || rd_empty !== !(m_opened && m_pos < NR)
                || rd_eof !== (m_opened && m_pos >= NR) || wr_full !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_rd cyc=%0d data=%h empty=%b eof=%b want %h %b %b",
                         cyc, rd_data, rd_empty, rd_eof, m_rdata,
                         !(m_opened && m_pos < NR), m_opened && m_pos >= NR);
            end
        end
    endtask

    initial begin
        clear_inputs();
        status_in   = '0;
        trn_reset_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 trn_reset_n = 1;

        test_reset();
        test_burst_write();
        test_write_overflow();
        test_full_read();
        test_read_seek();
        test_snapshot();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
